// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencer and its return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {
    REDIR_JUMP = 2'b00,
    REDIR_CALL = 2'b01,
    REDIR_RET  = 2'b10,
    REDIR_RSVD = 2'b11
  } redir_kind_t;

  localparam int unsigned PC_RESET_VEC = 0;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push while full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_m1;
  logic [CW-1:0]     cnt;

  // ptr is the next free slot; the top of stack sits one below it
  assign ptr_m1 = ptr - PW'(1);
  assign top    = mem[ptr_m1];
  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(RAS_DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_addr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr_m1;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: start cycle, redirect/stall/increment priority, RAS-backed returns.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RESET_VEC = PC_RESET_VEC,
  parameter int          RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_kind,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic [ADDR_W-1:0] redirect_link,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_underflow
);

  redir_kind_t       kind;
  logic              do_call;
  logic              do_ret;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;

  assign kind    = redir_kind_t'(redirect_kind);
  assign do_call = pc_valid && redirect_valid && (kind == REDIR_CALL);
  assign do_ret  = pc_valid && redirect_valid && (kind == REDIR_RET);
  assign ras_pop = do_ret && !ras_empty;

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (do_call),
    .pop       (ras_pop),
    .push_addr (redirect_link),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= ADDR_W'(RESET_VEC);
      pc_valid      <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (!pc_valid) begin
      // start edge: RESET_VEC becomes the first real fetch, inputs ignored
      pc_valid      <= 1'b1;
      ras_underflow <= 1'b0;
    end else begin
      ras_underflow <= 1'b0;
      if (redirect_valid) begin
        unique case (kind)
          REDIR_CALL: pc <= redirect_addr;
          REDIR_RET: begin
            if (ras_empty) begin
              pc            <= redirect_addr;
              ras_underflow <= 1'b1;
            end else begin
              pc <= ras_top;
            end
          end
          REDIR_JUMP, REDIR_RSVD: pc <= redirect_addr;
        endcase
      end else if (!stall) begin
        pc <= pc + ADDR_W'(STEP);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset/start, stall vs redirect, call/return, RAS overflow, wrap, async reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, rv;
  logic [1:0]  kind;
  logic [15:0] raddr, rlink;
  logic [15:0] pc;
  logic        pc_valid, ras_empty, ras_full, ras_underflow;

  logic        stall8, rv8;
  logic [1:0]  kind8;
  logic [7:0]  raddr8, rlink8;
  logic [7:0]  pc8;
  logic        pc_valid8, ras_empty8, ras_full8, ras_underflow8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(rv),
    .redirect_kind(kind), .redirect_addr(raddr), .redirect_link(rlink),
    .pc(pc), .pc_valid(pc_valid), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_underflow(ras_underflow)
  );

  pc_sequencer #(.ADDR_W(8), .STEP(4)) dut8 (
    .clk(clk), .reset(reset), .stall(stall8), .redirect_valid(rv8),
    .redirect_kind(kind8), .redirect_addr(raddr8), .redirect_link(rlink8),
    .pc(pc8), .pc_valid(pc_valid8), .ras_empty(ras_empty8), .ras_full(ras_full8),
    .ras_underflow(ras_underflow8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [1:0] k, input logic [15:0] a, input logic [15:0] l);
    rv = 1'b1; kind = k; raddr = a; rlink = l;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; rv = 1'b0; kind = 2'b00; raddr = '0; rlink = '0;
    stall8 = 1'b0; rv8 = 1'b0; kind8 = 2'b00; raddr8 = '0; rlink8 = '0;
    #2 reset = 1'b0;

    // reset held for 3 cycles
    repeat (3) step();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_valid", 32'(pc_valid), 32'h0);
    check("rst_empty", 32'(ras_empty), 32'h1);
    check("rst_full", 32'(ras_full), 32'h0);
    check("rst_uflow", 32'(ras_underflow), 32'h0);

    // start edge, then sequential fetch; a redirect on the start edge is ignored
    reset = 1'b1;
    redir(2'b00, 16'h0777, 16'h0);
    step();
    check("start_valid", 32'(pc_valid), 32'h1);
    check("start_pc", 32'(pc), 32'h0);
    rv = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("seq_pc", 32'(pc), 32'(i));
    end

    // stall vs redirect
    redir(2'b00, 16'h0010, 16'h0);
    step();
    check("jump_pc", 32'(pc), 32'h0010);
    rv = 1'b0; stall = 1'b1;
    step();
    check("stall1_pc", 32'(pc), 32'h0010);
    step();
    check("stall2_pc", 32'(pc), 32'h0010);
    redir(2'b00, 16'h0200, 16'h0);
    step();
    check("jump_over_stall", 32'(pc), 32'h0200);
    rv = 1'b0; stall = 1'b0;
    step();
    check("post_jump_inc", 32'(pc), 32'h0201);
    redir(2'b11, 16'h0250, 16'h0);
    step();
    check("rsvd_as_jump", 32'(pc), 32'h0250);
    check("rsvd_no_push", 32'(ras_empty), 32'h1);

    // call / return
    redir(2'b01, 16'h0300, 16'h0021);
    step();
    check("call_pc", 32'(pc), 32'h0300);
    check("call_empty", 32'(ras_empty), 32'h0);
    rv = 1'b0;
    step();
    check("call_inc", 32'(pc), 32'h0301);
    redir(2'b10, 16'h0999, 16'h0);
    step();
    check("ret_pc", 32'(pc), 32'h0021);
    check("ret_empty", 32'(ras_empty), 32'h1);
    check("ret_no_uflow", 32'(ras_underflow), 32'h0);

    // overflow: five calls into a four-deep stack
    for (int i = 0; i < 5; i++) begin
      redir(2'b01, 16'(16'h0300 + i), 16'(16'h00A1 + i));
      step();
      check("ovf_call_pc", 32'(pc), 32'(16'h0300 + i));
      check("ovf_full", 32'(ras_full), (i >= 3) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      redir(2'b10, 16'h0400, 16'h0);
      step();
      check("ovf_ret_pc", 32'(pc), 32'(16'h00A5 - i));
      check("ovf_ret_full", 32'(ras_full), 32'h0);
      check("ovf_ret_uflow", 32'(ras_underflow), 32'h0);
    end
    check("ovf_drained", 32'(ras_empty), 32'h1);
    redir(2'b10, 16'h0400, 16'h0);
    step();
    check("uflow_pc", 32'(pc), 32'h0400);
    check("uflow_pulse", 32'(ras_underflow), 32'h1);
    check("uflow_empty", 32'(ras_empty), 32'h1);
    rv = 1'b0;
    step();
    check("uflow_clear", 32'(ras_underflow), 32'h0);
    check("uflow_inc", 32'(pc), 32'h0401);

    // 8-bit wrap with STEP = 4
    rv8 = 1'b1; kind8 = 2'b00; raddr8 = 8'hFC;
    step();
    check("wrap_jump", 32'(pc8), 32'hFC);
    rv8 = 1'b0;
    step();
    check("wrap_pc", 32'(pc8), 32'h00);
    step();
    check("wrap_next", 32'(pc8), 32'h04);

    // async reset between edges with two RAS entries
    redir(2'b01, 16'h0500, 16'h0051);
    step();
    redir(2'b01, 16'h0600, 16'h0052);
    step();
    rv = 1'b0;
    check("pre_rst_empty", 32'(ras_empty), 32'h0);
    #3 reset = 1'b0;
    #1;
    check("arst_pc", 32'(pc), 32'h0);
    check("arst_valid", 32'(pc_valid), 32'h0);
    check("arst_empty", 32'(ras_empty), 32'h1);
    step();
    check("arst_hold_valid", 32'(pc_valid), 32'h0);
    reset = 1'b1;
    step();
    check("restart_valid", 32'(pc_valid), 32'h1);
    check("restart_pc", 32'(pc), 32'h0);
    step();
    check("restart_inc", 32'(pc), 32'h1);
    redir(2'b10, 16'h0123, 16'h0);
    step();
    check("restart_ret_pc", 32'(pc), 32'h0123);
    check("restart_ret_uflow", 32'(ras_underflow), 32'h1);
    rv = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
